// File: rtl/xor_bist_ctrl.sv
// Self-test sequencer for the lab XOR datapath: sweeps all {a,b} vectors, samples c
// after a fixed latency and accumulates a saturating mismatch count over several passes.
//
// state | meaning
// IDLE  | waiting for start, dut_a/dut_b held low, last results retained
// RUN   | sweeping vectors, one sample per LATENCY cycles
// DONE  | results valid, waiting for start (rerun) or abort (back to IDLE)
module xor_bist_ctrl #(
    parameter int LATENCY = 1,
    parameter int PASSES  = 1,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [1:0]       first_err_vec
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [3:0]       lat_cnt, lat_nxt;
    logic [7:0]       pass_cnt, pass_nxt;
    logic [1:0]       vec_idx, vec_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic             fv_nxt;
    logic [1:0]       fev_nxt;
    logic [1:0]       ab_nxt;
    logic             tc, last_smp, mismatch, launch;

    // Terminal count: this edge is the one where the down-counter would reach zero.
    assign tc       = (lat_cnt == 4'd1);
    assign last_smp = tc && (vec_idx == 2'd3) && (pass_cnt == 8'(PASSES - 1));
    assign mismatch = (dut_c !== (dut_a ^ dut_b));
    assign launch   = (state != RUN) && (state_nxt == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            lat_cnt         <= '0;
            pass_cnt        <= '0;
            vec_idx         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 2'b00;
            dut_a           <= 1'b0;
            dut_b           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state           <= state_nxt;
            lat_cnt         <= lat_nxt;
            pass_cnt        <= pass_nxt;
            vec_idx         <= vec_nxt;
            err_cnt         <= err_nxt;
            first_err_valid <= fv_nxt;
            first_err_vec   <= fev_nxt;
            dut_a           <= ab_nxt[1];
            dut_b           <= ab_nxt[0];
            busy            <= (state_nxt == RUN);
            done            <= (state_nxt == DONE);
            pass            <= (state_nxt == DONE) && (err_nxt == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!abort && start) state_nxt = RUN;
            end
            RUN: begin
                if (abort)         state_nxt = IDLE;
                else if (last_smp) state_nxt = DONE;
            end
            DONE: begin
                if (abort)      state_nxt = IDLE;
                else if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lat_nxt  = lat_cnt;
        pass_nxt = pass_cnt;
        vec_nxt  = vec_idx;
        err_nxt  = err_cnt;
        fv_nxt   = first_err_valid;
        fev_nxt  = first_err_vec;
        if (launch) begin
            lat_nxt  = 4'(LATENCY);
            pass_nxt = '0;
            vec_nxt  = '0;
            err_nxt  = '0;
            fv_nxt   = 1'b0;
            fev_nxt  = 2'b00;
        end else if (state == RUN && !abort) begin
            if (tc) begin
                lat_nxt = 4'(LATENCY);
                vec_nxt = vec_idx + 2'd1;
                if (vec_idx == 2'd3) pass_nxt = pass_cnt + 8'd1;
                if (mismatch) begin
                    if (err_cnt != {ERR_W{1'b1}}) err_nxt = err_cnt + ERR_W'(1);
                    if (!first_err_valid) begin
                        fv_nxt  = 1'b1;
                        fev_nxt = {dut_a, dut_b};
                    end
                end
            end else begin
                lat_nxt = lat_cnt - 4'd1;
            end
        end
        // Counters are parked at zero whenever no sweep is active.
        if (state_nxt != RUN) begin
            lat_nxt  = '0;
            pass_nxt = '0;
            vec_nxt  = '0;
        end
        ab_nxt = (state_nxt == RUN) ? vec_nxt : 2'b00;
    end

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// Bench for xor_bist_ctrl: four instances with different latency/pass/width settings,
// driven by a configurable delayed/faulty XOR model and checked against a sample-level model.
`timescale 1ns/1ps
module tb_xor_bist_ctrl;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start_v = '0;
    logic [3:0] abort_v = '0;
    logic [3:0] c_v;
    wire  [3:0] dut_a_v, dut_b_v, busy_v, done_v, pass_v, fv_v;
    wire  [7:0] err_v [NI];
    wire  [1:0] fev_v [NI];
    wire  [1:0] err3;

    int         dly  [NI];
    int         mode [NI];
    logic [3:0] mask [NI];
    logic [1:0] hist [NI][16];

    int tests_run = 0;
    int tests_failed = 0;

    assign err_v[3] = {6'b0, err3};

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction
    function automatic int passes_of(input int i);
        return (i == 1) ? 3 : ((i == 3) ? 2 : 1);
    endfunction
    function automatic int errw_of(input int i);
        return (i == 3) ? 2 : 8;
    endfunction

    // XOR unit model: 0 ideal, 1 stuck-at-0, 2 inverted, 3 per-vector flip mask, 4 undriven
    function automatic logic c_fn(input int md, input logic [3:0] mk, input logic [1:0] v);
        case (md)
            0:       return v[1] ^ v[0];
            1:       return 1'b0;
            2:       return ~(v[1] ^ v[0]);
            3:       return v[1] ^ v[0] ^ mk[v];
            default: return 1'bx;
        endcase
    endfunction

    xor_bist_ctrl #(.LATENCY(1), .PASSES(1), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .dut_a(dut_a_v[0]), .dut_b(dut_b_v[0]), .dut_c(c_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
        .first_err_valid(fv_v[0]), .first_err_vec(fev_v[0]));
    xor_bist_ctrl #(.LATENCY(1), .PASSES(3), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .dut_a(dut_a_v[1]), .dut_b(dut_b_v[1]), .dut_c(c_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
        .first_err_valid(fv_v[1]), .first_err_vec(fev_v[1]));
    xor_bist_ctrl #(.LATENCY(3), .PASSES(1), .ERR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .dut_a(dut_a_v[2]), .dut_b(dut_b_v[2]), .dut_c(c_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
        .first_err_valid(fv_v[2]), .first_err_vec(fev_v[2]));
    xor_bist_ctrl #(.LATENCY(1), .PASSES(2), .ERR_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(abort_v[3]),
        .dut_a(dut_a_v[3]), .dut_b(dut_b_v[3]), .dut_c(c_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_cnt(err3),
        .first_err_valid(fv_v[3]), .first_err_vec(fev_v[3]));

    always #5 clk = ~clk;

    // hist[i][k] holds the {a,b} value that was driven k+1 cycles before the current one.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                for (int j = 0; j < 16; j++) hist[i][j] <= 2'b00;
            end else begin
                hist[i][0] <= {dut_a_v[i], dut_b_v[i]};
                for (int j = 1; j < 16; j++) hist[i][j] <= hist[i][j-1];
            end
        end
    end

    always_comb begin
        c_v = '0;
        for (int i = 0; i < NI; i++)
            c_v[i] = c_fn(mode[i], mask[i],
                          (dly[i] <= 1) ? {dut_a_v[i], dut_b_v[i]} : hist[i][dly[i]-2]);
    end

    // Sample k of a run lands on edge (k+1)*L after launch and checks vector k%4; the c it sees
    // comes from the vector driven dly cycles earlier (00 before launch).
    task automatic ref_model(input int i, output int err, output bit fv, output logic [1:0] fev);
        int L, P, cnt, s, t, sat;
        logic [1:0] sv, dv;
        logic c, e;
        L = lat_of(i); P = passes_of(i); cnt = 0; fv = 1'b0; fev = 2'b00;
        for (int k = 0; k < 4 * P; k++) begin
            sv = 2'(k % 4);
            s  = (k + 1) * L;
            t  = s - dly[i];
            dv = (t < 0) ? 2'b00 : 2'((t / L) % 4);
            c  = c_fn(mode[i], mask[i], dv);
            e  = sv[1] ^ sv[0];
            if (c !== e) begin
                cnt++;
                if (!fv) begin fv = 1'b1; fev = sv; end
            end
        end
        sat = (1 << errw_of(i)) - 1;
        err = (cnt > sat) ? sat : cnt;
    endtask

    task automatic run_inst(input int i, input string nm, input bit restart_mid);
        int exp_err, cyc, L, P;
        bit exp_fv, seq_ok;
        logic [1:0] exp_fev;
        L = lat_of(i); P = passes_of(i);
        repeat (20) @(negedge clk);
        ref_model(i, exp_err, exp_fv, exp_fev);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        cyc = 0; seq_ok = 1'b1;
        while (busy_v[i] === 1'b1 && cyc < 5000) begin
            if ({dut_a_v[i], dut_b_v[i]} !== 2'((cyc / L) % 4)) seq_ok = 1'b0;
            cyc++;
            start_v[i] = restart_mid && (cyc == 2);
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        tests_run++;
        if (cyc != 4 * L * P) begin
            tests_failed++; $display("FAIL %s busy_len: got %0d cycles expected %0d", nm, cyc, 4 * L * P);
        end
        tests_run++;
        if (!seq_ok) begin
            tests_failed++; $display("FAIL %s vec_seq: got out-of-order vectors expected 00,01,10,11 each %0d cycles", nm, L);
        end
        tests_run++;
        if (done_v[i] !== 1'b1) begin
            tests_failed++; $display("FAIL %s done: got %b expected 1", nm, done_v[i]);
        end
        tests_run++;
        if (pass_v[i] !== (exp_err == 0)) begin
            tests_failed++; $display("FAIL %s pass: got %b expected %0d", nm, pass_v[i], exp_err == 0);
        end
        tests_run++;
        if (err_v[i] !== 8'(exp_err)) begin
            tests_failed++; $display("FAIL %s err_cnt: got %0d expected %0d", nm, err_v[i], exp_err);
        end
        tests_run++;
        if (fv_v[i] !== exp_fv) begin
            tests_failed++; $display("FAIL %s first_err_valid: got %b expected %b", nm, fv_v[i], exp_fv);
        end
        tests_run++;
        if (fev_v[i] !== exp_fev) begin
            tests_failed++; $display("FAIL %s first_err_vec: got %b expected %b", nm, fev_v[i], exp_fev);
        end
        tests_run++;
        if ({dut_a_v[i], dut_b_v[i]} !== 2'b00) begin
            tests_failed++; $display("FAIL %s ab_idle: got %b expected 00", nm, {dut_a_v[i], dut_b_v[i]});
        end
    endtask

    task automatic set_model(input int i, input int d, input int md);
        dly[i] = d; mode[i] = md; mask[i] = 4'h0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if ({dut_a_v[i], dut_b_v[i], busy_v[i], done_v[i], pass_v[i], fv_v[i]} !== 6'b0 ||
                err_v[i] !== 8'd0 || fev_v[i] !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_u%0d: got ab=%b busy=%b done=%b pass=%b err=%0d fv=%b fev=%b expected all 0",
                         i, {dut_a_v[i], dut_b_v[i]}, busy_v[i], done_v[i], pass_v[i], err_v[i], fv_v[i], fev_v[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_model(0, 1, 0); run_inst(0, "ideal_l1", 1'b0);
        set_model(0, 1, 1); run_inst(0, "stuck0", 1'b0);
        // restart straight from DONE with a failing result held: counters must clear
        set_model(0, 1, 0); run_inst(0, "start_in_done", 1'b0);
        set_model(1, 1, 2); run_inst(1, "inverted_p3", 1'b0);
        set_model(1, 1, 0); run_inst(1, "start_in_run_ignored", 1'b1);
    endtask

    task automatic test_latency();
        set_model(2, 3, 0); run_inst(2, "lat3_delay3", 1'b0);
        set_model(0, 3, 0); run_inst(0, "lat1_delay3", 1'b0);
        set_model(0, 1, 4); run_inst(0, "c_undriven", 1'b0);
    endtask

    task automatic test_saturate();
        set_model(3, 1, 2); run_inst(3, "saturate_w2", 1'b0);
        abort_v[3] = 1'b1;
        @(negedge clk);
        abort_v[3] = 1'b0;
        tests_run++;
        if (done_v[3] !== 1'b0 || busy_v[3] !== 1'b0 || pass_v[3] !== 1'b0) begin
            tests_failed++; $display("FAIL abort_in_done: got done=%b busy=%b pass=%b expected 0,0,0", done_v[3], busy_v[3], pass_v[3]);
        end
        tests_run++;
        if (err_v[3] !== 8'd3 || fv_v[3] !== 1'b1 || fev_v[3] !== 2'b00) begin
            tests_failed++; $display("FAIL abort_in_done_hold: got err=%0d fv=%b fev=%b expected 3,1,00", err_v[3], fv_v[3], fev_v[3]);
        end
    endtask

    task automatic test_abort();
        int cyc;
        set_model(2, 1, 2);
        repeat (20) @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        cyc = 0;
        while ({dut_a_v[2], dut_b_v[2]} !== 2'b10 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc >= 50) begin
            tests_failed++; $display("FAIL abort_wait_vec2: got timeout after %0d cycles expected vector 10", cyc);
        end
        abort_v[2] = 1'b1;
        @(negedge clk);
        abort_v[2] = 1'b0;
        tests_run++;
        if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || {dut_a_v[2], dut_b_v[2]} !== 2'b00) begin
            tests_failed++; $display("FAIL abort_run: got busy=%b done=%b ab=%b expected 0,0,00", busy_v[2], done_v[2], {dut_a_v[2], dut_b_v[2]});
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (err_v[2] !== 8'd2 || fv_v[2] !== 1'b1 || fev_v[2] !== 2'b00 || busy_v[2] !== 1'b0) begin
            tests_failed++; $display("FAIL abort_partial: got err=%0d fv=%b fev=%b busy=%b expected 2,1,00,0", err_v[2], fv_v[2], fev_v[2], busy_v[2]);
        end
        start_v[2] = 1'b1; abort_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0; abort_v[2] = 1'b0;
        tests_run++;
        if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || err_v[2] !== 8'd2 || {dut_a_v[2], dut_b_v[2]} !== 2'b00) begin
            tests_failed++; $display("FAIL start_abort_same: got busy=%b done=%b err=%0d ab=%b expected 0,0,2,00",
                                     busy_v[2], done_v[2], err_v[2], {dut_a_v[2], dut_b_v[2]});
        end
    endtask

    task automatic test_reset_midrun();
        set_model(1, 1, 2);
        repeat (20) @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({dut_a_v[1], dut_b_v[1], busy_v[1], done_v[1], pass_v[1], fv_v[1]} !== 6'b0 ||
            err_v[1] !== 8'd0 || fev_v[1] !== 2'b00) begin
            tests_failed++; $display("FAIL reset_midrun: got ab=%b busy=%b done=%b err=%0d fv=%b fev=%b expected all 0",
                                     {dut_a_v[1], dut_b_v[1]}, busy_v[1], done_v[1], err_v[1], fv_v[1], fev_v[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int i;
        for (int n = 0; n < 10; n++) begin
            i = int'($urandom_range(0, NI - 1));
            dly[i]  = int'($urandom_range(1, lat_of(i) + 2));
            mode[i] = int'($urandom_range(0, 4));
            mask[i] = 4'($urandom_range(0, 15));
            run_inst(i, $sformatf("random%0d_u%0d_d%0d_m%0d", n, i, dly[i], mode[i]), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            dly[i] = 1; mode[i] = 0; mask[i] = 4'h0;
        end
        test_reset();
        test_basic();
        test_latency();
        test_saturate();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xor_bist_ctrl.md
Name: xor_bist_ctrl

Overview:
Built-in self-test sequencer for the lab XOR datapath (inputs a, b; output c). On start it drives all four {a,b} combinations into the XOR unit. It waits a configurable latency, samples c and compares it to a^b. It accumulates an error count over a configurable number of passes and reports pass/fail. It sits between the lab top level (start/status) and the XOR instance.

Parameters:
LATENCY, 1, cycles from the edge that drives a/b to the edge that samples c; legal range 1..15
PASSES, 1, number of full 4-vector sweeps per run; legal range 1..255
ERR_W, 8, width of error counter

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled on posedge
abort  input  1  synchronous abort of a run in progress
dut_a  output  1  a input to XOR datapath
dut_b  output  1  b input to XOR datapath
dut_c  input  1  c output of XOR datapath
busy  output  1  run in progress
done  output  1  run complete, results valid
pass  output  1  done and zero errors
err_cnt  output  ERR_W  mismatches this run, saturating
first_err_valid  output  1  at least one mismatch this run
first_err_vec  output  2  {a,b} of first mismatch this run

Behaviour:
- Reset (rst_n low, async): state IDLE; dut_a=dut_b=0; busy=done=pass=0; err_cnt=0; first_err_valid=0; first_err_vec=0; all internal counters 0.
- States: IDLE, RUN, DONE.
- Vector order: vec_idx 0..3 maps to {a,b} = 00, 01, 10, 11. a is bit 1, b is bit 0.
- IDLE, start=1 at edge E0:
  - go to RUN and clear err_cnt, first_err_valid and first_err_vec.
  - drive vector 0 on dut_a/dut_b at E0.
  - load latency counter with LATENCY and pass counter with 0.
- RUN:
  - The latency counter decrements each edge.
  - At the edge where it would reach 0, the block samples dut_c against dut_a^dut_b, the values currently driven.
  - In that same edge it drives the next vector and reloads the counter.
  - Each vector is therefore held for exactly LATENCY cycles.
  - After vector 3 the pass counter increments and vec_idx wraps to 0.
  - After the sample of vector 3 of the final pass, go to DONE and set dut_a=dut_b=0.
  - Total busy duration is exactly 4*LATENCY*PASSES cycles.
- Mismatch handling:
  - err_cnt increments by 1 and saturates at 2^ERR_W-1 (no wrap).
  - If first_err_valid=0, set it and capture first_err_vec = sampled {a,b}.
  - Later mismatches never overwrite first_err_vec.
- dut_c equal to X/Z counts as a mismatch; compare with a case-equality check against the expected value.
- busy=1 exactly when state is RUN.
- done=1 exactly when state is DONE. pass = done & (err_cnt==0).
- DONE holds the results until start or abort.
  - start in DONE starts a new run immediately, with the same timing as from IDLE.
  - abort in DONE returns to IDLE, clears done and keeps err_cnt and first_err_*.
- start while in RUN: ignored.
- abort in RUN: return to IDLE next edge with dut_a=dut_b=0. No further samples. err_cnt and first_err_* hold partial results; done stays 0.
- start and abort in the same cycle: abort wins and start is ignored.
- rst_n asserted mid-run: immediate return to reset values, with no completion.
- Outputs are registered; none is combinational from start, abort or dut_c.

Test Plan:
- LATENCY=1, PASSES=1, registered ideal XOR (c=a^b delayed 1 cycle), pulse start -> busy high 4 cycles; dut_{a,b} sequence 00,01,10,11; done=1, pass=1, err_cnt=0, first_err_valid=0.
- Same setup, dut_c stuck at 0 -> err_cnt=2, first_err_vec=2'b01, pass=0, done=1.
- dut_c = ~(a^b), PASSES=3 -> err_cnt=12, first_err_vec=2'b00, busy exactly 12 cycles.
- LATENCY=3 with 3-stage delayed XOR model -> busy exactly 12 cycles, pass=1. The same model with LATENCY=1 -> pass=0.
- ERR_W=2, always-wrong c, PASSES=2 -> err_cnt saturates at 3 (no wrap).
- Control and reset edge cases:
  - abort during vector 2 -> IDLE next cycle, done=0, dut_a=dut_b=0.
  - start+abort in the same cycle from IDLE -> stays IDLE.
  - rst_n low mid-run -> all outputs 0 asynchronously.
  - start in DONE -> new run and err_cnt cleared.
